// File: rtl/mixer_16.sv
// ---------------------------------------------------------------------------
// mixer_16 -- sixteen-channel audio mixer for the synth voice path.
//
// Sums sixteen unsigned 16-bit voice samples into one 20-bit unsigned sum.
// There is no truncation, scaling or saturation. The largest possible sum is
// 16 * 65535 = 20'hFFFF0, so the output width holds every sum.
//
// Ports
//   clk             in   1   system clock, rising-edge active
//   rst_n           in   1   asynchronous active-low reset (clears mixed_q only)
//   signal1..16     in  16   channel samples, unsigned
//   mixed_signal    out 20   combinational sum of all channels (latency 0)
//   mixed_q         out 20   mixed_signal registered on rising clk (latency 1)
// ---------------------------------------------------------------------------
module mixer_16 #(
  parameter int IN_W  = 16,
  parameter int N_CH  = 16,
  parameter int OUT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  signal1,
  input  logic [IN_W-1:0]  signal2,
  input  logic [IN_W-1:0]  signal3,
  input  logic [IN_W-1:0]  signal4,
  input  logic [IN_W-1:0]  signal5,
  input  logic [IN_W-1:0]  signal6,
  input  logic [IN_W-1:0]  signal7,
  input  logic [IN_W-1:0]  signal8,
  input  logic [IN_W-1:0]  signal9,
  input  logic [IN_W-1:0]  signal10,
  input  logic [IN_W-1:0]  signal11,
  input  logic [IN_W-1:0]  signal12,
  input  logic [IN_W-1:0]  signal13,
  input  logic [IN_W-1:0]  signal14,
  input  logic [IN_W-1:0]  signal15,
  input  logic [IN_W-1:0]  signal16,
  output logic [OUT_W-1:0] mixed_signal,
  output logic [OUT_W-1:0] mixed_q
);

  // Each tree level is one bit wider than the level below it, so no carry is
  // ever lost: 17, 18, 19, then 20 bits at the root.
  localparam int L1_W = IN_W + 1;
  localparam int L2_W = IN_W + 2;
  localparam int L3_W = IN_W + 3;

  logic [IN_W-1:0] samples [N_CH];
  logic [L1_W-1:0] lvl1    [8];
  logic [L2_W-1:0] lvl2    [4];
  logic [L3_W-1:0] lvl3    [2];
  logic [OUT_W-1:0] mixed_d;

  assign samples[0]  = signal1;
  assign samples[1]  = signal2;
  assign samples[2]  = signal3;
  assign samples[3]  = signal4;
  assign samples[4]  = signal5;
  assign samples[5]  = signal6;
  assign samples[6]  = signal7;
  assign samples[7]  = signal8;
  assign samples[8]  = signal9;
  assign samples[9]  = signal10;
  assign samples[10] = signal11;
  assign samples[11] = signal12;
  assign samples[12] = signal13;
  assign samples[13] = signal14;
  assign samples[14] = signal15;
  assign samples[15] = signal16;

  // Balanced tree: 8 -> 4 -> 2 -> 1 adders, operands zero-extended by one bit
  // per level so the adder width matches the result width.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lvl1
      assign lvl1[gi] = {1'b0, samples[2*gi]} + {1'b0, samples[2*gi+1]};
    end
    for (gi = 0; gi < 4; gi++) begin : g_lvl2
      assign lvl2[gi] = {1'b0, lvl1[2*gi]} + {1'b0, lvl1[2*gi+1]};
    end
    for (gi = 0; gi < 2; gi++) begin : g_lvl3
      assign lvl3[gi] = {1'b0, lvl2[2*gi]} + {1'b0, lvl2[2*gi+1]};
    end
  endgenerate

  assign mixed_d      = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
  assign mixed_signal = mixed_d;

  // The combinational path is independent of reset; only the registered copy
  // is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mixed_q <= '0;
    end else begin
      mixed_q <= mixed_d;
    end
  end

endmodule

// File: tb/tb_mixer_16.sv
// ---------------------------------------------------------------------------
// Testbench for mixer_16: directed vector table, walking-channel sweep,
// reset sequences and a randomized soak against an integer-sum model.
// ---------------------------------------------------------------------------
module tb_mixer_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] sig [16];
  logic [19:0] mixed_signal;
  logic [19:0] mixed_q;

  int n_cmp;
  int n_err;

  typedef struct {
    string       name;
    logic [15:0] in [16];
    logic [19:0] exp_sum;
  } vec_t;

  vec_t vecs [5];

  mixer_16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signal1      (sig[0]),
    .signal2      (sig[1]),
    .signal3      (sig[2]),
    .signal4      (sig[3]),
    .signal5      (sig[4]),
    .signal6      (sig[5]),
    .signal7      (sig[6]),
    .signal8      (sig[7]),
    .signal9      (sig[8]),
    .signal10     (sig[9]),
    .signal11     (sig[10]),
    .signal12     (sig[11]),
    .signal13     (sig[12]),
    .signal14     (sig[13]),
    .signal15     (sig[14]),
    .signal16     (sig[15]),
    .mixed_signal (mixed_signal),
    .mixed_q      (mixed_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer sum of the current channel values.
  function automatic int model_sum();
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(sig[i]);
    return s;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input int exp_v);
    n_cmp++;
    if (act !== 20'(exp_v)) begin
      n_err++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, 20'(exp_v));
    end
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 16; i++) sig[i] = v;
  endtask

  initial begin
    int exp_q;
    n_cmp = 0;
    n_err = 0;

    // Directed table with hand-computed sums.
    vecs[0].name = "all_zero";
    for (int i = 0; i < 16; i++) vecs[0].in[i] = 16'h0000;
    vecs[0].exp_sum = 20'h00000;
    vecs[1].name = "all_ffff";
    for (int i = 0; i < 16; i++) vecs[1].in[i] = 16'hFFFF;
    vecs[1].exp_sum = 20'hFFFF0;
    vecs[2].name = "ch7_1234";
    for (int i = 0; i < 16; i++) vecs[2].in[i] = 16'h0000;
    vecs[2].in[6] = 16'h1234;
    vecs[2].exp_sum = 20'h01234;
    vecs[3].name = "ramp_1_16";
    for (int i = 0; i < 16; i++) vecs[3].in[i] = 16'(i + 1);
    vecs[3].exp_sum = 20'd136;
    vecs[4].name = "all_8000";
    for (int i = 0; i < 16; i++) vecs[4].in[i] = 16'h8000;
    vecs[4].exp_sum = 20'h80000;

    // Reset state.
    rst_n = 1'b0;
    set_all(16'h0000);
    #2;
    check("reset_q", mixed_q, 0);
    check("reset_sum", mixed_signal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_q", mixed_q, 0);

    // Table: apply while clk is low, sum must settle with no edge.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 16; i++) sig[i] = vecs[v].in[i];
      #1;
      check({vecs[v].name, "_sum"}, mixed_signal, int'(vecs[v].exp_sum));
      @(posedge clk); #1;
      check({vecs[v].name, "_q"}, mixed_q, int'(vecs[v].exp_sum));
    end

    // Walking single channel.
    for (int ch = 0; ch < 16; ch++) begin
      @(negedge clk); #1;
      set_all(16'h0000);
      sig[ch] = 16'h1234;
      #1;
      check($sformatf("walk%0d_sum", ch + 1), mixed_signal, 'h1234);
      @(posedge clk); #1;
      check($sformatf("walk%0d_q", ch + 1), mixed_q, 'h1234);
    end

    // Reset asserted mid-stream between edges.
    @(negedge clk); #1;
    set_all(16'h8000);
    @(posedge clk); #1;
    check("pre_rst_q", mixed_q, 'h80000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_q", mixed_q, 0);
    check("midrst_sum", mixed_signal, 'h80000);
    @(posedge clk); #1;
    check("held_rst_q", mixed_q, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_q_before_edge", mixed_q, 0);
    @(posedge clk); #1;
    check("release_q", mixed_q, 'h80000);

    // Random soak: inputs change just after each rising edge.
    for (int c = 0; c < 50000; c++) begin
      @(posedge clk);
      exp_q = model_sum();
      #1;
      check("soak_q", mixed_q, exp_q);
      for (int i = 0; i < 16; i++) sig[i] = 16'($urandom);
      #1;
      check("soak_sum_hi", mixed_signal, model_sum());
      @(negedge clk); #1;
      check("soak_sum_lo", mixed_signal, model_sum());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
